// File: rtl/leg_pkg.sv
// Shared types and constants for the LEG fetch/decode front end.
package leg_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam int          IMM1_BIT     = 7;
  localparam int          IMM2_BIT     = 6;
  localparam logic [2:0]  REG_PC_IDX   = 3'd6;
  localparam logic [2:0]  REG_ZERO_IDX = 3'd7;
  localparam int          INSTR_BYTES  = 4;
  localparam logic [7:0]  OPCODE_MASK  = 8'h3F;

endpackage

// File: rtl/leg_operand_select.sv
// Resolves one ALU operand from an immediate flag, the arg byte and register data.
// Build option LEG_PC_OPERAND_EN maps register index 6 to the instruction PC.
module leg_operand_select
  import leg_pkg::*;
#(
  parameter int RF_REGS = 6
) (
  input  logic       imm,
  input  logic [7:0] arg,
  input  logic [7:0] rf_rdata,
  input  logic [7:0] pc,
  output logic [7:0] operand
);

  logic [2:0] idx;
  assign idx = arg[2:0];

`ifndef LEG_PC_OPERAND_EN
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  always_comb begin
    operand = 8'd0;
    if (imm) begin
      operand = arg;
    end else if (int'(idx) < RF_REGS) begin
      operand = rf_rdata;
`ifdef LEG_PC_OPERAND_EN
    end else if (idx == REG_PC_IDX) begin
      operand = pc;
`endif
    end else begin
      // Index 7 (and 6 without PC operands) reads as the zero register.
      operand = 8'd0;
    end
  end

endmodule

// File: rtl/leg_fetch_decode.sv
// LEG front end: fetches 4-byte instructions, resolves operands, hands bundles to execute.
// Build option LEG_PC_OPERAND_EN enables PC-as-operand on register index 6.
module leg_fetch_decode
  import leg_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'd0,
  parameter int         RF_REGS  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  output logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [2:0] rf_raddr1,
  input  logic [7:0] rf_rdata1,
  output logic [2:0] rf_raddr2,
  input  logic [7:0] rf_rdata2,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_opcode,
  output logic [7:0] out_op1,
  output logic [7:0] out_op2,
  output logic [7:0] out_dest,
  output logic [7:0] out_pc
);

  state_t     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [7:0] pc_q, pc_d;
  logic       vld_p1, vld_d;
  logic       load_out;

  logic [7:0] opc_p0, arg1_p0, arg2_p0, dest_p0;
  logic [7:0] op1_res, op2_res;

  assign prog_addr = (state_q == FETCH && k_q < 3'(INSTR_BYTES)) ? pc_q + {5'd0, k_q} : pc_q;
  assign rf_raddr1 = arg1_p0[2:0];
  assign rf_raddr2 = arg2_p0[2:0];
  assign out_valid = vld_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      k_q     <= 3'd0;
      pc_q    <= PC_RESET;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pc_q    <= pc_d;
      vld_p1  <= vld_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    pc_d     = pc_q;
    vld_d    = vld_p1;
    load_out = 1'b0;
    case (state_q)
      FETCH: begin
        if (k_q == 3'(INSTR_BYTES)) begin
          state_d = READ;
          k_d     = 3'd0;
        end else if (k_q != 3'd0 || run_en) begin
          // run_en only gates the start of a fetch, never a fetch in flight.
          k_d = k_q + 3'd1;
        end
      end
      READ: begin
        state_d  = VALID;
        vld_d    = 1'b1;
        load_out = 1'b1;
      end
      VALID: begin
        if (out_ready) begin
          state_d = FETCH;
          k_d     = 3'd0;
          pc_d    = pc_q + 8'(INSTR_BYTES);
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = FETCH;
        k_d     = 3'd0;
      end
    endcase
    // A redirect wins over everything, including a same-cycle handshake.
    if (redirect_valid) begin
      state_d  = FETCH;
      k_d      = 3'd0;
      pc_d     = redirect_pc;
      vld_d    = 1'b0;
      load_out = 1'b0;
    end
  end

  // ---- stage p0: instruction bytes, one per fetch cycle after the ROM latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opc_p0  <= 8'd0;
      arg1_p0 <= 8'd0;
      arg2_p0 <= 8'd0;
      dest_p0 <= 8'd0;
    end else if (state_q == FETCH) begin
      case (k_q)
        3'd1:    opc_p0  <= prog_data;
        3'd2:    arg1_p0 <= prog_data;
        3'd3:    arg2_p0 <= prog_data;
        3'd4:    dest_p0 <= prog_data;
        default: ;
      endcase
    end
  end

  leg_operand_select #(.RF_REGS(RF_REGS)) u_sel_op1 (
    .imm      (opc_p0[IMM1_BIT]),
    .arg      (arg1_p0),
    .rf_rdata (rf_rdata1),
    .pc       (pc_q),
    .operand  (op1_res)
  );

  leg_operand_select #(.RF_REGS(RF_REGS)) u_sel_op2 (
    .imm      (opc_p0[IMM2_BIT]),
    .arg      (arg2_p0),
    .rf_rdata (rf_rdata2),
    .pc       (pc_q),
    .operand  (op2_res)
  );

  // ---- stage p1: bundle presented to execute, held until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_opcode <= 8'd0;
      out_op1    <= 8'd0;
      out_op2    <= 8'd0;
      out_dest   <= 8'd0;
      out_pc     <= 8'd0;
    end else if (load_out) begin
      out_opcode <= opc_p0 & OPCODE_MASK;
      out_op1    <= op1_res;
      out_op2    <= op2_res;
      out_dest   <= dest_p0;
      out_pc     <= pc_q;
    end
  end

endmodule

// File: tb/tb_leg_fetch_decode.sv
// Self-checking bench for leg_fetch_decode: vector table, directed corner sequences, random run.
module tb_leg_fetch_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic [2:0] rf_raddr1, rf_raddr2;
  logic [7:0] rf_rdata1, rf_rdata2;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_opcode, out_op1, out_op2, out_dest, out_pc;

  logic [7:0] rom [256];
  logic [7:0] rf  [8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= rom[prog_addr];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  leg_fetch_decode dut (
    .clk            (clk),
    .rst            (rst),
    .run_en         (run_en),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .rf_raddr1      (rf_raddr1),
    .rf_rdata1      (rf_rdata1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata2      (rf_rdata2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_opcode     (out_opcode),
    .out_op1        (out_op1),
    .out_op2        (out_op2),
    .out_dest       (out_dest),
    .out_pc         (out_pc)
  );

`ifdef LEG_PC_OPERAND_EN
  localparam logic [7:0] V4_OP1 = 8'h10;
  localparam logic [7:0] FC_OP1 = 8'hFC;
`else
  localparam logic [7:0] V4_OP1 = 8'h00;
  localparam logic [7:0] FC_OP1 = 8'h00;
`endif

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] e_opc, e_op1, e_op2, e_dest;
  } vec_t;
  vec_t vt [6];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of clock edges until out_valid is seen, or -1 on timeout.
  task automatic wait_bundle(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_bundle(input string tag, input logic [7:0] opc, input logic [7:0] op1,
                              input logic [7:0] op2, input logic [7:0] dest, input logic [7:0] pc);
    check1({tag, ".valid"}, out_valid, 1'b1);
    check8({tag, ".opcode"}, out_opcode, opc);
    check8({tag, ".op1"}, out_op1, op1);
    check8({tag, ".op2"}, out_op2, op2);
    check8({tag, ".dest"}, out_dest, dest);
    check8({tag, ".pc"}, out_pc, pc);
  endtask

  // Reference operand resolution straight from the instruction-format rules.
  function automatic logic [7:0] ref_operand(input logic imm, input logic [7:0] arg, input logic [7:0] pc);
    int idx;
    if (imm) return arg;
    idx = int'(arg[2:0]);
    if (idx < 6) return rf[idx];
`ifdef LEG_PC_OPERAND_EN
    if (idx == 6) return pc;
`endif
    return 8'd0;
  endfunction

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    logic [7:0] pc_exp;

    rst = 1'b0;
    run_en = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'd0;
    for (int i = 0; i < 256; i++) rom[i] = 8'd0;
    rf[0] = 8'h11; rf[1] = 8'h05; rf[2] = 8'h07; rf[3] = 8'h33;
    rf[4] = 8'h44; rf[5] = 8'h55; rf[6] = 8'hAA; rf[7] = 8'hBB;

    vt[0] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h05, 8'h07, 8'h03};
    vt[1] = '{8'hC1, 8'h09, 8'h14, 8'h02, 8'h01, 8'h09, 8'h14, 8'h02};
    vt[2] = '{8'h85, 8'hF9, 8'h0B, 8'h7E, 8'h05, 8'hF9, 8'h33, 8'h7E};
    vt[3] = '{8'h4A, 8'h0F, 8'h27, 8'h00, 8'h0A, 8'h00, 8'h27, 8'h00};
    vt[4] = '{8'h3F, 8'h0E, 8'h00, 8'hFF, 8'h3F, V4_OP1, 8'h11, 8'hFF};
    vt[5] = '{8'h12, 8'h2C, 8'h35, 8'h80, 8'h12, 8'h44, 8'h55, 8'h80};
    for (int i = 0; i < 6; i++) begin
      rom[4*i]   = vt[i].b0;
      rom[4*i+1] = vt[i].b1;
      rom[4*i+2] = vt[i].b2;
      rom[4*i+3] = vt[i].b3;
    end
    rom[24] = 8'h00; rom[25] = 8'h03; rom[26] = 8'h04; rom[27] = 8'h05;
    rom[28] = 8'hC0; rom[29] = 8'h77; rom[30] = 8'h88; rom[31] = 8'h01;
    rom[32] = 8'hFF; rom[33] = 8'hFF; rom[34] = 8'hFF; rom[35] = 8'hFF;
    rom[8'h40] = 8'h8C; rom[8'h41] = 8'h66; rom[8'h42] = 8'h01; rom[8'h43] = 8'h0A;
    rom[8'hFC] = 8'h00; rom[8'hFD] = 8'h06; rom[8'hFE] = 8'h01; rom[8'hFF] = 8'h09;

    // Reset state
    tick();
    tick();
    check8("rst.prog_addr", prog_addr, 8'h00);
    check1("rst.valid", out_valid, 1'b0);
    check8("rst.opcode", out_opcode, 8'h00);
    check8("rst.op1", out_op1, 8'h00);
    check8("rst.op2", out_op2, 8'h00);
    check8("rst.dest", out_dest, 8'h00);
    check8("rst.pc", out_pc, 8'h00);
    rst = 1'b1;

    // Vector table: back-to-back instructions with out_ready high
    for (int i = 0; i < 6; i++) begin
      wait_bundle(n);
      check32($sformatf("vec%0d.latency", i), n, (i == 0) ? 6 : 7);
      check_bundle($sformatf("vec%0d", i), vt[i].e_opc, vt[i].e_op1, vt[i].e_op2,
                   vt[i].e_dest, 8'(4 * i));
    end

    // Back-pressure: bundle at pc 20 held for 10 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_bundle("stall", 8'h12, 8'h44, 8'h55, 8'h80, 8'd20);
      check8("stall.prog_addr", prog_addr, 8'd20);
    end
    out_ready = 1'b1;
    tick();
    check1("accept.valid", out_valid, 1'b0);
    check8("accept.prog_addr", prog_addr, 8'd24);
    wait_bundle(n);
    check32("pc24.latency", n, 6);
    check_bundle("pc24", 8'h00, 8'h33, 8'h44, 8'h05, 8'd24);

    // run_en low at k=0 holds the fetch
    run_en = 1'b0;
    tick();
    check1("hold.valid", out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check8("hold.prog_addr", prog_addr, 8'd28);
    end
    run_en = 1'b1;
    wait_bundle(n);
    check32("pc28.latency", n, 6);
    check_bundle("pc28", 8'h00, 8'h77, 8'h88, 8'h01, 8'd28);

    // Redirect at k=2 discards the partial fetch
    tick();
    tick();
    tick();
    check8("k2.prog_addr", prog_addr, 8'd34);
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    check8("redir.prog_addr", prog_addr, 8'h40);
    check1("redir.valid", out_valid, 1'b0);
    wait_bundle(n);
    check32("redir.latency", n, 6);
    check_bundle("redir", 8'h0C, 8'h66, 8'h05, 8'h0A, 8'h40);

    // Redirect coinciding with a handshake takes the target, not pc+4
    redirect_valid = 1'b1;
    redirect_pc = 8'hFC;
    tick();
    redirect_valid = 1'b0;
    check1("redir_hs.valid", out_valid, 1'b0);
    check8("redir_hs.prog_addr", prog_addr, 8'hFC);
    wait_bundle(n);
    check32("pcFC.latency", n, 6);
    check_bundle("pcFC", 8'h00, FC_OP1, 8'h05, 8'h09, 8'hFC);
    tick();
    check8("wrap.prog_addr", prog_addr, 8'h00);

    // Reset pulled during READ
    redirect_valid = 1'b1;
    redirect_pc = 8'h30;
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();
    check8("read.prog_addr", prog_addr, 8'h30);
    rst = 1'b0;
    #1;
    check8("rst_read.prog_addr", prog_addr, 8'h00);
    check1("rst_read.valid", out_valid, 1'b0);
    check8("rst_read.op2", out_op2, 8'h00);
    check8("rst_read.pc", out_pc, 8'h00);
    tick();
    rst = 1'b1;
    wait_bundle(n);
    check32("restart.latency", n, 6);
    check_bundle("restart", 8'h00, 8'h05, 8'h07, 8'h03, 8'h00);

    // out_valid drops without a clock edge when reset asserts
    rst = 1'b0;
    #1;
    check1("rst_async.valid", out_valid, 1'b0);

    // Random run against the reference model
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
    tick();
    rst = 1'b1;
    pc_exp = 8'h00;
    acc = 0;
    for (int c = 0; c < 4000 && acc < 40; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      run_en = ($urandom_range(0, 4) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom);
      if (out_valid && out_ready) begin
        logic [7:0] opc;
        opc = rom[pc_exp];
        check8("rnd.pc", out_pc, pc_exp);
        check8("rnd.opcode", out_opcode, {2'b00, opc[5:0]});
        check8("rnd.op1", out_op1, ref_operand(opc[7], rom[8'(pc_exp + 8'd1)], pc_exp));
        check8("rnd.op2", out_op2, ref_operand(opc[6], rom[8'(pc_exp + 8'd2)], pc_exp));
        check8("rnd.dest", out_dest, rom[8'(pc_exp + 8'd3)]);
        acc++;
      end
      if (redirect_valid) pc_exp = redirect_pc;
      else if (out_valid && out_ready) pc_exp = pc_exp + 8'd4;
    end
    check1("rnd.accepts", acc >= 40, 1'b1);
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leg_fetch_decode.md
Name: leg_fetch_decode

Overview:
- Front-end stage of the 8-bit LEG core; sits directly upstream of the ALU.
- Fetches 4-byte instructions from a byte-wide synchronous program ROM: opcode, arg1, arg2, dest.
- Resolves immediate flags and register-file reads.
- Presents opcode, both 8-bit operands, destination and instruction PC to the ALU/execute stage over a valid/ready handshake.

Parameters:
- PC_RESET, 8'd0, program counter value after reset.
- RF_REGS, 6, number of general registers served by the external register file (indices 0..RF_REGS-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run_en  in  1  1 = fetching allowed; 0 = hold before starting a new fetch.
- prog_addr  out  8  program ROM byte address.
- prog_data  in  8  ROM data, valid one cycle after prog_addr.
- rf_raddr1  out  3  register index for operand 1 (combinational read).
- rf_rdata1  in  8  register data for operand 1.
- rf_raddr2  out  3  register index for operand 2.
- rf_rdata2  in  8  register data for operand 2.
- redirect_valid  in  1  jump taken downstream.
- redirect_pc  in  8  jump target.
- out_valid  out  1  instruction bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_opcode  out  8  {2'b00, opcode[5:0]}; ALU uses [3:0].
- out_op1  out  8  resolved operand 1.
- out_op2  out  8  resolved operand 2.
- out_dest  out  8  dest byte, passed through unchanged.
- out_pc  out  8  address of the instruction's opcode byte.

Behaviour:
- Reset (rst=0, async):
  - pc=PC_RESET, state=FETCH, k=0.
  - prog_addr=PC_RESET, out_valid=0, all out_* data=0.
- FETCH:
  - Byte counter k runs 0..4.
  - k<4: prog_addr=pc+k (mod 256).
  - k>=1: capture prog_data into byte[k-1].
  - k=4: go to READ.
  - Total: 5 cycles per fetch.
  - If run_en=0 at k=0, stay at k=0 and issue no advance. Once k>0, run_en is ignored until the bundle is dispatched.
- READ (1 cycle):
  - rf_raddr1=arg1[2:0], rf_raddr2=arg2[2:0].
  - Operands latch into out_op1/out_op2 at the end of this cycle.
  - out_valid=1 next cycle; go to VALID.
- Operand resolve (per operand):
  - opcode[7] (arg1) / opcode[6] (arg2) = 1 → immediate, value = arg byte.
  - Else index = arg[2:0]:
    - index < RF_REGS → rf_rdata.
    - index 6 → see optional feature.
    - index 7 → 8'd0.
  - arg[7:3] are ignored in register mode.
- VALID:
  - All out_* held stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: pc ← pc+4 (wraps 252→0), out_valid=0 next cycle, state=FETCH k=0.
- No internal hazard logic:
  - Next fetch starts only after the handshake, so any write-back done on the handshake cycle is visible ≥6 cycles later in READ.
- Redirect (any state):
  - pc ← redirect_pc, state=FETCH k=0, out_valid=0 next cycle; partially fetched bytes are discarded.
  - Redirect coinciding with a handshake: the bundle counts as accepted and pc takes redirect_pc, not pc+4.
  - Unaligned redirect_pc is legal; fetch addresses wrap mod 256.
- Reset asserted mid-fetch: immediate return to reset state; out_valid drops asynchronously.
- Steady-state throughput: one instruction per 7 cycles with out_ready=1.

Optional Feature:
- Macro LEG_PC_OPERAND_EN.
- Defined: register index 6 resolves to the instruction's out_pc value (PC-as-operand, for relative addressing).
- Undefined: index 6 resolves to 8'd0, same as index 7.
- Immediate handling is unaffected either way.

Decomposition:
- Package leg_pkg:
  - FSM state enum {FETCH, READ, VALID}.
  - IMM1_BIT=7, IMM2_BIT=6.
  - REG_PC_IDX=3'd6, REG_ZERO_IDX=3'd7.
  - INSTR_BYTES=4, OPCODE_MASK=8'h3F.
- Sub-module leg_operand_select: combinational; inputs imm flag, arg byte, rf_rdata, pc; outputs resolved operand. Instantiated twice, for op1 and op2.

Test Plan:
- ROM[0..3]={8'h00,8'd1,8'd2,8'd3}, r1=5, r2=7, out_ready=1 → out_valid rises on cycle 6 after reset release; opcode=0, op1=5, op2=7, dest=3, pc=0; next prog_addr=4.
- ROM[4..7]={8'hC1,8'd9,8'd20,8'd2} (both imm) → opcode=8'h01, op1=9, op2=20, pc=4; rf data ignored.
- Hold out_ready=0 for 10 cycles on a valid bundle → all out_* stable, prog_addr unchanged; out_ready=1 → one accept, pc+4.
- Assert redirect_valid with redirect_pc=8'h40 at k=2 → bytes discarded; prog_addr=8'h40 next cycle; next bundle has out_pc=8'h40.
- pc=8'hFC, accept → prog_addr wraps to 8'h00; arg1 register index 6 yields 8'hFC with LEG_PC_OPERAND_EN, 8'h00 without.
- Pull rst low during READ → out_valid=0 and prog_addr=PC_RESET immediately; fetch restarts at k=0 after release.
